// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// FSM encoding and error flag bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } tx_ctrl_state_e;

    localparam int ERR_FIFO = 0;
    localparam int ERR_ACK  = 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Both flops reset to RESET_VAL.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// Sequencer from TX FIFO to bit shifter: CTS flow control,
// ack timeout, inter-frame gap, frame counter and sticky errors.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16,
    parameter bit CTS_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 cts_n,
    input  logic                 fifo_empty,
    input  logic                 fifo_error,
    input  logic [7:0]           fifo_data,
    output logic                 fifo_read,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 active,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    input  logic                 cnt_clr,
    output logic [1:0]           err_sticky,
    input  logic                 err_clr
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit NO_GAP = (GAP_CYCLES == 0);

    tx_ctrl_state_e state_q, state_d;

    logic                 fifo_read_q, fifo_read_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 active_q, active_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]           err_q, err_d;
    logic [TW-1:0]        ack_cnt_q, ack_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;

    logic cts_sync;
    logic cts_ok;
    logic ack_hit;
    logic gap_hit;
    logic timeout;
    logic frame_done;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_cts_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (cts_n),
        .q_o    (cts_sync)
    );

    assign cts_ok     = !CTS_EN || !cts_sync;
    assign ack_hit    = (ack_cnt_q == TW'(ACK_TIMEOUT));
    assign gap_hit    = (gap_cnt_q == GW'(GAP_CYCLES));
    assign timeout    = (state_q == WAIT_ACK) && !tx_busy && ack_hit;
    assign frame_done = (state_q == WAIT_DONE) && !tx_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty && cts_ok) state_d = POP;
            end
            POP:  state_d = LOAD;
            LOAD: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy) state_d = WAIT_DONE;
                else if (ack_hit) begin
                    if (NO_GAP) state_d = IDLE;
                    else        state_d = GAP;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (NO_GAP) state_d = IDLE;
                    else        state_d = GAP;
                end
            end
            GAP: begin
                if (gap_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_read_d = (state_d == POP);
        tx_start_d  = (state_q == LOAD);
        tx_data_d   = (state_q == LOAD) ? fifo_data : tx_data_q;
        active_d    = (state_d != IDLE);

        // timeout count is 1 in the tx_start cycle
        ack_cnt_d = ack_cnt_q;
        if (state_q == LOAD)          ack_cnt_d = TW'(1);
        else if (state_q == WAIT_ACK) ack_cnt_d = ack_cnt_q + TW'(1);

        gap_cnt_d = gap_cnt_q;
        if (state_q != GAP)  gap_cnt_d = GW'(1);
        else if (!gap_hit)   gap_cnt_d = gap_cnt_q + GW'(1);

        frame_cnt_d = frame_cnt_q;
        if (frame_done) frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        if (cnt_clr)    frame_cnt_d = '0;

        err_d = err_q;
        if (err_clr)    err_d = '0;
        if (fifo_error) err_d[ERR_FIFO] = 1'b1;
        if (timeout)    err_d[ERR_ACK] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_read_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            active_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= '0;
            ack_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            fifo_read_q <= fifo_read_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            active_q    <= active_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            ack_cnt_q   <= ack_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign fifo_read  = fifo_read_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign active     = active_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO and shifter models, byte scoreboard,
// directed corner cases, vector table and randomized bursts.
module tb_uart_tx_ctrl;

    localparam int GAP   = 16;
    localparam int ACKTO = 64;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          cts_n;
    logic          fifo_empty;
    logic          fifo_error;
    logic [7:0]    fifo_data;
    logic          fifo_read;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          active;
    logic [CW-1:0] frame_cnt;
    logic          cnt_clr;
    logic [1:0]    err_sticky;
    logic          err_clr;

    uart_tx_ctrl #(
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACKTO),
        .CNT_WIDTH  (CW),
        .CTS_EN     (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cts_n     (cts_n),
        .fifo_empty(fifo_empty),
        .fifo_error(fifo_error),
        .fifo_data (fifo_data),
        .fifo_read (fifo_read),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .active    (active),
        .frame_cnt (frame_cnt),
        .cnt_clr   (cnt_clr),
        .err_sticky(err_sticky),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         len;
        logic [1:0] exp_cnt;
    } vec_t;

    int         n_run = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] fq[$];
    logic [7:0] sq[$];
    int         busy_left = 0;
    int         shift_len = 10;
    bit         ack_en = 1;
    bit         rand_len = 0;
    int         done_frames = 0;
    int         rd_count = 0;
    int         rd_cyc = -100;
    int         start_count = 0;
    int         last_start = 0;
    int         last_len = 0;
    bit         have_last = 0;
    bit         chk_space = 0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_run++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic tick();
        logic rd;
        logic st;
        rd = fifo_read;
        st = tx_start;
        if (cnt_clr) done_frames = 0;
        @(posedge clk);
        #1;
        cyc++;
        if (rd && fq.size() > 0) fifo_data = fq.pop_front();
        else                     fifo_data = 8'($urandom);
        fifo_empty = (fq.size() == 0);
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) done_frames++;
        end
        if (st && ack_en) busy_left = shift_len;
        tx_busy = (busy_left > 0);
        if (fifo_read) begin
            check("pop_nonempty", 32'(fq.size() > 0), 1);
            rd_count++;
            rd_cyc = cyc;
        end
        if (tx_start) begin
            start_count++;
            check("start_latency", cyc - rd_cyc, 2);
            check("sb_nonempty", 32'(sq.size() > 0), 1);
            if (sq.size() > 0) check("tx_data", tx_data, sq.pop_front());
            check("cnt_at_start", frame_cnt, done_frames % (1 << CW));
            if (chk_space && have_last)
                check("spacing", cyc - last_start, last_len + 1 + GAP + 4);
            if (rand_len) shift_len = $urandom_range(1, 12);
            last_start = cyc;
            last_len   = shift_len;
            have_last  = 1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        sq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_start(input int lim, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (tx_start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now(nm);
    endtask

    task automatic wait_inactive(input int lim, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (!active) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now(nm);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (!active && fq.size() == 0 && sq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   k;
        int   s;
        int   r0;
        int   c;
        int   n;
        bit   m_err0;
        bit   ok;

        vecs[0] = '{8'h5A, 4, 2'd2};
        vecs[1] = '{8'hC3, 7, 2'd3};
        vecs[2] = '{8'h00, 3, 2'd0};
        vecs[3] = '{8'hFF, 1, 2'd1};

        reset_n    = 1'b0;
        enable     = 1'b0;
        cts_n      = 1'b1;
        fifo_empty = 1'b1;
        fifo_error = 1'b0;
        fifo_data  = 8'h00;
        tx_busy    = 1'b0;
        cnt_clr    = 1'b0;
        err_clr    = 1'b0;
        ticks(3);
        check("rst_read_start", {fifo_read, tx_start}, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_active", active, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err", err_sticky, 0);

        reset_n = 1'b1;
        enable  = 1'b1;
        cts_n   = 1'b0;
        ticks(3);

        // single byte: pop next cycle, start two cycles after pop
        shift_len = 10;
        push(8'hA5);
        k = cyc;
        wait_start(20, "t1_start");
        check("t1_latency", cyc - k, 3);
        s = cyc;
        wait_inactive(60, "t1_inactive");
        check("t1_idle_at", cyc - s, 10 + 2 + GAP);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_reads", rd_count, 1);

        // frames 2..5 walk the 2-bit counter through its wrap
        foreach (vecs[i]) begin
            shift_len = vecs[i].len;
            push(vecs[i].data);
            wait_start(20, "vec_start");
            wait_idle(100, "vec_idle");
            check("vec_cnt", frame_cnt, vecs[i].exp_cnt);
            check("vec_hold", tx_data, vecs[i].data);
        end

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr", frame_cnt, 0);

        // back-to-back burst
        chk_space = 1;
        have_last = 0;
        shift_len = 6;
        r0 = start_count;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_idle(300, "b2b_idle");
        check("b2b_starts", start_count - r0, 3);
        check("b2b_cnt", frame_cnt, 3);
        chk_space = 0;

        // clear coincident with increment
        shift_len = 5;
        push(8'h6B);
        wait_start(20, "clr_start");
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!tx_busy && i > 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("clr_fall");
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_wins", frame_cnt, 0);
        wait_idle(60, "clr_idle");
        check("clr_after", frame_cnt, 0);

        // flow control
        cts_n = 1'b1;
        ticks(3);
        r0 = rd_count;
        shift_len = 8;
        push(8'h4D);
        ticks(20);
        check("cts_hold", rd_count, r0);
        cts_n = 1'b0;
        c = cyc;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fifo_read) break;
        end
        check("cts_read_lat", cyc - c, 3);
        push(8'hB2);
        cts_n = 1'b1;
        wait_start(10, "cts_start");
        wait_inactive(60, "cts_inactive");
        ticks(30);
        check("cts_mid_hold", rd_count, r0 + 1);
        check("cts_mid_cnt", frame_cnt, done_frames % (1 << CW));
        cts_n = 1'b0;
        wait_idle(200, "cts_drain");
        check("cts_reads", rd_count, r0 + 2);

        // ack timeout
        ack_en = 0;
        r0 = done_frames;
        push(8'h3C);
        wait_start(20, "to_start");
        s = cyc;
        ticks(ACKTO - 1);
        check("to_early", err_sticky, 2'b00);
        tick();
        check("to_err", err_sticky, 2'b10);
        check("to_cnt", frame_cnt, r0 % (1 << CW));
        wait_inactive(40, "to_inactive");
        ack_en = 1;
        fifo_error = 1'b1;
        err_clr    = 1'b1;
        tick();
        fifo_error = 1'b0;
        err_clr    = 1'b0;
        check("err_set_wins", err_sticky, 2'b01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", err_sticky, 2'b00);

        // reset during WAIT_DONE
        shift_len = 20;
        push(8'h77);
        wait_start(20, "rst_start");
        ticks(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_strobes", {fifo_read, tx_start}, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_active", active, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        busy_left   = 0;
        tx_busy     = 1'b0;
        done_frames = 0;
        have_last   = 0;
        ticks(2);
        reset_n = 1'b1;
        ticks(3);
        shift_len = 4;
        push(8'h5E);
        k = cyc;
        wait_start(20, "post_rst_start");
        check("post_rst_lat", cyc - k, 3);
        wait_idle(60, "post_rst_idle");
        check("post_rst_cnt", frame_cnt, 1);

        // randomized bursts against the model
        rand_len  = 1;
        chk_space = 1;
        m_err0    = 0;
        for (int b = 0; b < 6; b++) begin
            have_last = 0;
            shift_len = $urandom_range(1, 12);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) push(8'($urandom));
            ok = 0;
            for (int i = 0; i < 400; i++) begin
                fifo_error = ($urandom_range(0, 15) == 0);
                if (fifo_error) m_err0 = 1;
                tick();
                if (!active && fq.size() == 0 && sq.size() == 0) begin
                    ok = 1;
                    break;
                end
            end
            fifo_error = 1'b0;
            tick();
            if (!ok) fail_now("rand_idle");
            check("rand_err0", err_sticky[0], m_err0);
            check("rand_cnt", frame_cnt, done_frames % (1 << CW));
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            m_err0  = 0;
        end
        chk_space = 0;
        rand_len  = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
